// File: rtl/tow_field.sv
`default_nettype none
// ============================================================================
// Module   : tow_field
// Purpose  : Tug-of-war playing field. Owns the rope position, detects button
//            press edges, decides round wins, keeps per-player round scores
//            and ends the match when either score reaches its maximum.
// Ports    : clk        - system clock
//            reset      - asynchronous, active-high reset
//            player1    - synchronised button level, pulls rope toward index 0
//            player2    - synchronised button level, pulls rope toward top index
//            lights     - one-hot rope position, all-zero outside PLAY
//            score1     - rounds won by player 1
//            score2     - rounds won by player 2
//            round_win  - one-cycle pulse after a win (bit0 = p1, bit1 = p2)
//            match_over - high once either score has reached its maximum
// Revision : 1.0 - initial release
// ============================================================================
module tow_field #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3,
  parameter int ROUND_GAP  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  player1,
  input  logic                  player2,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]    score1,
  output logic [SCORE_W-1:0]    score2,
  output logic [1:0]            round_win,
  output logic                  match_over
);

  localparam int POS_W = $clog2(NUM_LIGHTS);
  localparam int GAP_W = (ROUND_GAP > 1) ? $clog2(ROUND_GAP) : 1;

  localparam logic [POS_W-1:0]   POS_CENTRE = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(NUM_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(ROUND_GAP - 1);

  typedef enum logic [1:0] {
    ST_PLAY       = 2'd0,
    ST_WIN_HOLD   = 2'd1,
    ST_MATCH_OVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [1:0]         round_win_q, round_win_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               p1_q, p2_q;

  logic e1, e2, mv1, mv2;

  // Previous-press flops come out of reset high so a button held through
  // reset is not mistaken for a fresh press once reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PLAY;
      pos_q       <= POS_CENTRE;
      score1_q    <= '0;
      score2_q    <= '0;
      round_win_q <= 2'b00;
      gap_q       <= '0;
      p1_q        <= 1'b1;
      p2_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      round_win_q <= round_win_d;
      gap_q       <= gap_d;
      p1_q        <= player1;
      p2_q        <= player2;
    end
  end

  // Rising-edge detection; simultaneous edges cancel each other out.
  always_comb begin
    e1  = player1 & ~p1_q;
    e2  = player2 & ~p2_q;
    mv1 = e1 & ~e2;
    mv2 = e2 & ~e1;
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    round_win_d = 2'b00;
    gap_d       = gap_q;

    case (state_q)
      ST_PLAY: begin
        if (mv1) begin
          if (pos_q != '0) begin
            pos_d = pos_q - POS_W'(1);
          end else begin
            // A push past the end of the rope wins the round.
            score1_d    = score1_q + SCORE_W'(1);
            round_win_d = 2'b01;
            gap_d       = GAP_LOAD;
            state_d     = (score1_q == SCORE_MAX - SCORE_W'(1)) ? ST_MATCH_OVER
                                                                : ST_WIN_HOLD;
          end
        end else if (mv2) begin
          if (pos_q != POS_LAST) begin
            pos_d = pos_q + POS_W'(1);
          end else begin
            score2_d    = score2_q + SCORE_W'(1);
            round_win_d = 2'b10;
            gap_d       = GAP_LOAD;
            state_d     = (score2_q == SCORE_MAX - SCORE_W'(1)) ? ST_MATCH_OVER
                                                                : ST_WIN_HOLD;
          end
        end
      end

      ST_WIN_HOLD: begin
        if (gap_q == '0) begin
          pos_d   = POS_CENTRE;
          state_d = ST_PLAY;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      ST_MATCH_OVER: begin
        // Terminal until reset; everything is frozen.
      end

      default: begin
        state_d = ST_PLAY;
        pos_d   = POS_CENTRE;
      end
    endcase
  end

  always_comb begin
    lights = '0;
    if (state_q == ST_PLAY) begin
      lights[pos_q] = 1'b1;
    end
  end

  assign score1     = score1_q;
  assign score2     = score2_q;
  assign round_win  = round_win_q;
  assign match_over = (state_q == ST_MATCH_OVER);

endmodule
`default_nettype wire

// File: doc/tow_field.md
Name: tow_field

Overview:
- Parametrised successor to the tug-of-war input delegator.
- Owns the rope position directly and drives an N-light one-hot display.
- Detects press edges, decides round wins, and keeps per-player round scores.
- Ends the match when either score saturates; the board top level instantiates it between the input synchronisers and the LED/HEX drivers.

Parameters:
- NUM_LIGHTS, 9, number of rope lights. Must be odd and >= 3. Centre index C = (NUM_LIGHTS-1)/2.
- SCORE_W, 3, width of each score counter. Match point is MAX = 2^SCORE_W - 1.
- ROUND_GAP, 4, cycles spent in WIN_HOLD before the rope re-centres. Must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- player1  input  1  player 1 button level, already synchronised; pushes the light toward index 0
- player2  input  1  player 2 button level, already synchronised; pushes the light toward index NUM_LIGHTS-1
- lights  output  NUM_LIGHTS  one-hot rope position; all-zero outside PLAY
- score1  output  SCORE_W  player 1 rounds won
- score2  output  SCORE_W  player 2 rounds won
- round_win  output  2  one-cycle pulse in the cycle after a round is won; bit0 = player 1, bit1 = player 2
- match_over  output  1  high once either score reaches MAX

Behaviour:
- Reset (asynchronous, active-high):
  - state = PLAY, pos = C, score1 = score2 = 0, round_win = 0, gap counter = 0.
  - Previous-press registers p1_q and p2_q are set to 1, so a button held through reset does not count as a press.
  - lights = one-hot at C.
- Edge detect:
  - e1 = player1 & ~p1_q; e2 = player2 & ~p2_q.
  - p1_q and p2_q are updated every cycle in every state.
- Effective moves: mv1 = e1 & ~e2; mv2 = e2 & ~e1. Simultaneous edges produce no move.
- State PLAY, evaluated at each posedge:
  - mv1 and pos > 0: pos decrements.
  - mv2 and pos < NUM_LIGHTS-1: pos increments.
  - mv1 and pos == 0: player 1 wins the round. score1 increments, round_win = 01 for one cycle, gap counter loads ROUND_GAP-1.
  - mv2 and pos == NUM_LIGHTS-1: player 2 wins the round. score2 increments, round_win = 10 for one cycle, gap counter loads ROUND_GAP-1.
  - After a win: if the new score == MAX, go to MATCH_OVER; otherwise go to WIN_HOLD.
  - No move: everything holds.
- Latency: a press edge sampled at posedge k is visible on lights/score after posedge k (one cycle).
- State WIN_HOLD:
  - lights = 0 and all presses are ignored (p1_q/p2_q still track).
  - Gap counter decrements each cycle. When it is 0, pos = C and state returns to PLAY.
  - lights show C after ROUND_GAP cycles in WIN_HOLD.
- State MATCH_OVER:
  - lights = 0, match_over = 1, presses ignored, scores frozen.
  - The state is left only through reset.
- Scores never exceed MAX; the MATCH_OVER transition guarantees no wrap.
- round_win is registered; it is 00 in every cycle except the one following a win.
- match_over is combinational from state, i.e. effectively registered.
- Reset mid-round or mid-hold returns to the reset values immediately; the held-button rule applies after release.

Test Plan (NUM_LIGHTS=5, SCORE_W=2 so MAX=3, ROUND_GAP=2; C=2):
- Reset while player1 is held, then deassert reset with player1 still held for 3 cycles -> lights stay 5'b00100 and no move occurs.
- From centre, give player1 three separate 1-cycle pulses with a low cycle between each:
  - lights go 00010 -> 00001, then the third pulse wins.
  - round_win = 01 for one cycle, score1 = 1, lights = 00000 for 2 cycles, then 00100.
- Both players rise in the same cycle at pos 2 -> lights stay 00100 and the scores are unchanged. A player1 pulse in the next cycle after release moves the light to 00010.
- Hold player2 continuously for 10 cycles -> exactly one move to 01000; no repeat moves.
- Player 2 wins three rounds:
  - after the third win, score2 = 3, match_over = 1, lights = 0.
  - further pulses from either player change nothing.
  - reset clears score2 to 0 and match_over to 0, and lights return to 00100.
- Assert reset during WIN_HOLD (gap counter = 1) -> asynchronous clear: state PLAY, lights 00100, scores 0, round_win 00, all before the next clock edge.
